// File: rtl/mdu_multicycle.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Optional MADD/MSUB accumulate ops are enabled by defining MDU_MADD_EN.
//
// state  | meaning
// S_IDLE | ready to accept an md op; MTHI/MTLO complete here in one cycle
// S_BUSY | mult/div in flight; cnt counts the remaining busy cycles down to 0
module mdu_multicycle #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       md_op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
`endif

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               is_mul, is_div, is_div_q, accept, done;
    logic [2*WIDTH-1:0] prod_s, prod_u, mul_res;
    logic [WIDTH-1:0]   abs_a, abs_b, uq, ur, quo, rem;
    logic               sgn_div;
`ifdef MDU_MADD_EN
    logic [2*WIDTH-1:0] acc_q;
`endif

    always_comb begin
        is_mul = (md_op == OP_MULT) || (md_op == OP_MULTU);
`ifdef MDU_MADD_EN
        if ((md_op == OP_MADD) || (md_op == OP_MSUB)) is_mul = 1'b1;
`endif
        is_div   = (md_op == OP_DIV) || (md_op == OP_DIVU);
        is_div_q = (op_q == OP_DIV) || (op_q == OP_DIVU);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: if (start && (is_mul || is_div)) begin
                accept    = 1'b1;
                state_nxt = S_BUSY;
            end
            S_BUSY: if (cnt == '0) begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state == S_BUSY);

    // Signed divide works on magnitudes so most-negative / -1 wraps cleanly.
    always_comb begin
        prod_s  = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
        prod_u  = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        mul_res = (op_q == OP_MULTU) ? prod_u : prod_s;
`ifdef MDU_MADD_EN
        if (op_q == OP_MADD)      mul_res = acc_q + prod_s;
        else if (op_q == OP_MSUB) mul_res = acc_q - prod_s;
`endif
        sgn_div = (op_q == OP_DIV);
        abs_a   = (sgn_div && a_q[WIDTH-1]) ? -a_q : a_q;
        abs_b   = (sgn_div && b_q[WIDTH-1]) ? -b_q : b_q;
        uq      = (b_q == '0) ? '0 : abs_a / abs_b;
        ur      = (b_q == '0) ? '0 : abs_a % abs_b;
        quo     = (sgn_div && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -uq : uq;
        rem     = (sgn_div && a_q[WIDTH-1]) ? -ur : ur;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            HI    <= '0;
            LO    <= '0;
            cnt   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
`ifdef MDU_MADD_EN
            acc_q <= '0;
`endif
        end else begin
            if (accept) begin
                op_q  <= md_op;
                a_q   <= A;
                b_q   <= B;
                cnt   <= is_div ? DIV_LOAD : MUL_LOAD;
`ifdef MDU_MADD_EN
                acc_q <= {HI, LO};
`endif
            end else if (busy && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end

            if (done) begin
                if (!is_div_q)      {HI, LO} <= mul_res;
                else if (b_q != '0) {HI, LO} <= {rem, quo};
            end else if (start && (state == S_IDLE)) begin
                if (md_op == OP_MTHI)      HI <= A;
                else if (md_op == OP_MTLO) LO <= A;
            end
        end
    end

endmodule
